// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment codes and sizing helper for the seven_seg_scan display driver
package seven_seg_pkg;

  // Active-low segment codes, bit order g..a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - hex nibble to active-low seven-segment code
module seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - double-buffered, dead-timed N-digit seven-segment scanner
// Optional leading-zero blanking when SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_start
);

  localparam int IDX_W = idx_width(N_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_start_q, frame_start_d;

  logic                  pre_end;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   an_sel;
  logic [6:0]            dec_seg;

  always_comb begin
    pre_end = (pre_q == PRE_LAST);
    wrap    = pre_end && (idx_q == IDX_LAST);
    pre_d   = pre_end ? '0 : pre_q + 1'b1;
    idx_d   = idx_q;
    if (pre_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the wrap cycle bypasses the pending registers straight into the active frame.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic [N_DIGITS-1:0] hi_zero;

  // hi_zero[k]: digit k and every digit above it are zero in the active frame.
  always_comb begin
    hi_zero = '0;
    hi_zero[N_DIGITS-1] = (act_val_q[4*N_DIGITS-1 -: 4] == 4'h0);
    for (int k = N_DIGITS - 2; k >= 0; k--) begin
      hi_zero[k] = hi_zero[k+1] && (act_val_q[4*k +: 4] == 4'h0);
    end
  end
`endif

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = act_val_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        an_sel[k] = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
        if (k >= 1) begin
          cur_blank = hi_zero[k];
        end
`endif
      end
    end
  end

  seg_decode u_seg_decode (
    .nibble (cur_nib),
    .seg_n  (dec_seg)
  );

  // Prescaler count 0 is the dead-time slot: all anodes and cathodes off.
  always_comb begin
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    an_d          = '1;
    frame_start_d = (pre_q == '0) && (idx_q == '0);
    if (pre_q != '0) begin
      an_d  = an_sel;
      seg_d = cur_blank ? SEG_BLANK : dec_seg;
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q         <= '0;
      idx_q         <= '0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      pend_val_q    <= pend_val_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed self-checking bench for seven_seg_scan (N_DIGITS=4, REFRESH_DIV=4)
module tb_seven_seg_scan;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int          cyc;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [12:0] obs;
  logic [12:0] expv;

  // Hand-entered segment table, bit order g..a, active low
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seven_seg_scan #(
    .N_DIGITS    (4),
    .REFRESH_DIV (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Expected {an, seg, dp, frame_start} at sample c (c=0 is the first edge after reset release).
  function automatic logic [12:0] exp_out(input int c, input logic [15:0] v, input logic [3:0] dps);
    int         p;
    int         d;
    logic [3:0] a;
    logic [3:0] nib;
    logic [6:0] s;
    p = c % 4;
    d = (c / 4) % 4;
    if (p == 0) return {4'hF, 7'h7F, 1'b1, (d == 0)};
    a   = ~(4'b0001 << d);
    nib = v[4*d +: 4];
    s   = seg_tab[nib];
`ifdef SEVEN_SEG_LZB_EN
    if (d > 0 && (v >> (4*d)) == 16'h0) s = 7'h7F;
`endif
    return {a, s, ~dps[d], 1'b0};
  endfunction

  task automatic test_reset();
    reset = 1'b1; value = '0; dp_in = '0; load = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {an, seg, dp, frame_start};
      n_assert++;
      if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold i=%0d got=%h required=%h", i, obs, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
    reset = 1'b0;
    cyc = -1;
    step();
    obs = {an, seg, dp, frame_start};
    n_assert++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL first_dead got=%h required=%h", obs, {4'hF, 7'h7F, 1'b1, 1'b1});
    end
    step();
    obs = {an, seg, dp, frame_start};
    n_assert++;
    if (obs !== {4'hE, 7'b1000000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL first_lit got=%h required=%h", obs, {4'hE, 7'b1000000, 1'b1, 1'b0});
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 30; i++) begin
      step();
      obs  = {an, seg, dp, frame_start};
      expv = exp_out(cyc, 16'h0000, 4'h0);
      n_assert++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL idle cyc=%0d got=%h required=%h", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_load_mid_frame();
    while (cyc % 16 != 4) step();
    value = 16'h1A3F; dp_in = 4'b0100; load = 1'b1;
    step();
    value = '0; dp_in = '0; load = 1'b0;
    while (cyc % 16 != 15) begin
      step();
      obs  = {an, seg, dp, frame_start};
      expv = exp_out(cyc, 16'h0000, 4'h0);
      n_assert++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL mid_old cyc=%0d got=%h required=%h", cyc, obs, expv);
      end
    end
    for (int i = 0; i < 16; i++) begin
      step();
      obs  = {an, seg, dp, frame_start};
      expv = exp_out(cyc, 16'h1A3F, 4'b0100);
      n_assert++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL mid_new cyc=%0d got=%h required=%h", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_two_loads();
    while (cyc % 16 != 2) step();
    value = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    while (cyc % 16 != 8) step();
    value = 16'h2222; load = 1'b1;
    step();
    load = 1'b0; value = '0;
    while (cyc % 16 != 15) begin
      step();
      obs  = {an, seg, dp, frame_start};
      expv = exp_out(cyc, 16'h1A3F, 4'b0100);
      n_assert++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL two_old cyc=%0d got=%h required=%h", cyc, obs, expv);
      end
    end
    for (int i = 0; i < 16; i++) begin
      step();
      obs  = {an, seg, dp, frame_start};
      expv = exp_out(cyc, 16'h2222, 4'h0);
      n_assert++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL two_last_wins cyc=%0d got=%h required=%h", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_wrap_load();
    while (cyc % 16 != 14) step();
    value = 16'hBEEF; dp_in = 4'b1001; load = 1'b1;
    step();
    value = '0; dp_in = '0; load = 1'b0;
    obs  = {an, seg, dp, frame_start};
    expv = exp_out(cyc, 16'h2222, 4'h0);
    n_assert++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL wrap_old_digit3 cyc=%0d got=%h required=%h", cyc, obs, expv);
    end
    n_assert++;
    if (dut.pend_valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pend_valid got=%b required=0", dut.pend_valid_q);
    end
    for (int i = 0; i < 32; i++) begin
      step();
      obs  = {an, seg, dp, frame_start};
      expv = exp_out(cyc, 16'hBEEF, 4'b1001);
      n_assert++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL wrap_beef cyc=%0d got=%h required=%h", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_lzb();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    for (int t = 0; t < 2; t++) begin
      while (cyc % 16 != 14) step();
      value = vals[t]; dp_in = 4'b0000; load = 1'b1;
      step();
      load = 1'b0; value = '0;
      for (int i = 0; i < 16; i++) begin
        step();
        obs  = {an, seg, dp, frame_start};
        expv = exp_out(cyc, vals[t], 4'h0);
        n_assert++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL lzb val=%h cyc=%0d got=%h required=%h", vals[t], cyc, obs, expv);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    while (cyc % 16 != 3) step();
    value = 16'h5555; dp_in = 4'b1111; load = 1'b1;
    step();
    value = '0; dp_in = '0; load = 1'b0;
    while (cyc % 16 != 9) step();
    reset = 1'b1;
    step();
    obs = {an, seg, dp, frame_start};
    n_assert++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs got=%h required=%h", obs, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    reset = 1'b0;
    cyc = -1;
    for (int i = 0; i < 32; i++) begin
      step();
      obs  = {an, seg, dp, frame_start};
      expv = exp_out(cyc, 16'h0000, 4'h0);
      n_assert++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL midreset_zero cyc=%0d got=%h required=%h", cyc, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_mid_frame();
    test_two_loads();
    test_wrap_load();
    test_lzb();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for an N-digit common-anode seven-segment display. It accepts a packed hexadecimal value and per-digit decimal points, and double-buffers them so a displayed frame never tears. It scans one digit per refresh period, with a one-cycle anti-ghosting dead time, and drives active-low segment, decimal-point and anode lines. It sits between the score/status registers and the board display pins, and replaces per-digit static decoders.

## Interface
- N_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clock cycles per digit period; legal range ≥ 2.

- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  4*N_DIGITS  hex nibbles; nibble i = value[4i+3:4i], where digit 0 is the rightmost/least significant.
- dp_in  in  N_DIGITS  decimal point request per digit; 1 = lit.
- load  in  1  single-cycle strobe that captures value and dp_in into the pending buffer.
- seg  out  7  segment cathodes, active-low; bit0=a … bit6=g.
- dp  out  1  decimal-point cathode, active-low.
- an  out  N_DIGITS  digit anodes, active-low, at most one low at a time.
- frame_start  out  1  one-cycle pulse when digit 0's period begins.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, digit index advances: k → k+1, and N_DIGITS-1 → 0.
- Double buffer:
  - load writes the pending registers, pend_val and pend_dp, and sets pend_valid.
  - When index wraps to 0, if pend_valid is set: the active registers take the pending contents and pend_valid clears.
  - The displayed frame only changes at a frame boundary.
  - If load coincides with the wrap cycle, the data presented on that load cycle is the data transferred (bypass). pend_valid ends cleared.
  - Multiple loads within one frame: the last one wins.
- Decode, hex to active-low segments:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000 (bits g..a).
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Dead time: on the first cycle of every digit period, an is all ones, seg=7'h7F and dp=1. For the remaining REFRESH_DIV-1 cycles, an[k]=0 and seg/dp show digit k.
- dp = ~active_dp[k] during the lit portion.

## Timing
- Reset values:
  - prescaler 0, index 0.
  - active and pending registers 0, pend_valid 0.
  - seg=7'h7F, dp=1, an all ones, frame_start 0.
- All outputs are registered. Each output reflects the index/prescaler state of the previous cycle, giving one cycle of latency.
- First cycle after reset release: dead time for digit 0, with frame_start=1. Next cycle: an=…1110, seg=1000000.
- Frame period = N_DIGITS*REFRESH_DIV cycles. frame_start pulses once per frame.
- Latency from load to display: from 1 cycle up to one full frame plus 1 cycle.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and any pending load is discarded.
- N_DIGITS=1: the index stays 0 and every period is a frame boundary.

## Configuration
- SEVEN_SEG_LZB_EN defined: leading-zero blanking is enabled.
  - Digit k (k ≥ 1) shows seg=7'h7F if it and all higher digits of the active value are 0.
  - The anode is still driven and dp still follows active_dp.
  - Digit 0 is never blanked.
- Undefined: every digit is always decoded, so zeros are shown.

## Structure
- Package seven_seg_pkg holds:
  - the 16 segment code constants and SEG_BLANK=7'h7F;
  - the digit-index width function, clog2 of N_DIGITS (minimum 1).
- Sub-module seg_decode: combinational nibble → 7-bit active-low code, instantiated once on the muxed active nibble.
- Leading-zero blanking is a per-digit "all higher zero" vector computed from the active registers only.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=4.
- Reset then idle: outputs are the reset values during reset. After release, frame_start pulses every 16 cycles and an cycles 1111,1110,1110,1110,1111,1101,… with seg=1000000 whenever lit.
- Load value=16'h1A3F, dp_in=4'b0100 mid-frame: the display stays 0 until the next frame_start. Afterwards digit 0=0001110, digit 1=0110000, digit 2=0001000 with dp=0, digit 3=1111001.
- Two loads in one frame (16'h1111, then 16'h2222): only 2222 is displayed; 1111 never appears.
- Load on the exact wrap cycle with 16'hBEEF: BEEF is displayed in the frame that starts there, and pend_valid is 0 afterwards.
- SEVEN_SEG_LZB_EN defined, value 16'h0050: digits 3 and 2 show 7F; digit 1=0010010; digit 0=1000000. Value 16'h0000 shows blanks except digit 0.
- Reset asserted for 1 cycle mid-scan after a pending load: the display returns to all zeros, and the pending data is never shown.
